mem_access_ctrl: RTL and testbench

- MEM-stage sequencer between the decoded memory-control bundle and the single-port data RAM bus.
- Bundle inputs: read/write flag, sign-extend flag, 4-bit byte select, store data.
- Checks alignment, builds byte enables and lane-replicated store data, and runs a req/ack handshake.
- Stalls the pipeline until the access completes and returns the aligned, extended load result.

---
 rtl/mem_access_ctrl_pkg.sv | 27 ++
 rtl/mem_access_ctrl_lane_align.sv | 64 ++++++
 rtl/mem_access_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the MEM-stage memory access sequencer:
//   - size-mask encodings carried on the mem_sel bus of the decode bundle
//   - data RAM bus widths
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  // Size mask carried by the decoded memory-control bundle.
  localparam int          MEM_SEL_BUS  = 4;
  localparam logic [3:0]  MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0]  MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0]  MEM_SEL_WORD = 4'b1111;

  // Data RAM bus: 32-bit data split into four byte lanes.
  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W   = RAM_DATA_W / 8;

  typedef enum logic [1:0] {
    MEM_ST_IDLE  = 2'd0,
    MEM_ST_BUSY  = 2'd1,
    MEM_ST_ABORT = 2'd2,
    MEM_ST_DONE  = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align  (purely combinational)
// Byte-lane steering for the data RAM bus.
//   Store side: st_sel/st_off/st_data -> sel_ok, misaligned, be, wdata
//               (size decode, alignment check, byte enables, store data
//               replicated across every lane it may land in)
//   Load side : ld_sel/ld_off/ld_sign/ld_rdata -> ld_result
//               (lane shift to bit 0, then sign- or zero-extension)
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [MEM_SEL_BUS-1:0] st_sel,
  input  logic [1:0]             st_off,
  input  logic [RAM_DATA_W-1:0]  st_data,
  output logic                   sel_ok,
  output logic                   misaligned,
  output logic [RAM_BE_W-1:0]    be,
  output logic [RAM_DATA_W-1:0]  wdata,
  input  logic [MEM_SEL_BUS-1:0] ld_sel,
  input  logic [1:0]             ld_off,
  input  logic                   ld_sign,
  input  logic [RAM_DATA_W-1:0]  ld_rdata,
  output logic [RAM_DATA_W-1:0]  ld_result
);

  logic [RAM_DATA_W-1:0] ld_shifted;

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sel_ok     = 1'b1;
    misaligned = 1'b0;
    be         = '0;
    wdata      = st_data;
    case (st_sel)
      MEM_SEL_BYTE: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      MEM_SEL_HALF: begin
        misaligned = st_off[0];
        be         = 4'b0011 << st_off;
        wdata      = {2{st_data[15:0]}};
      end
      MEM_SEL_WORD: begin
        misaligned = |st_off;
        be         = 4'b1111;
      end
      // Empty (or unrecognised) masks mean the bundle carries no access.
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_sel)
      MEM_SEL_BYTE: ld_result = {{24{ld_sign & ld_shifted[7]}},  ld_shifted[7:0]};
      MEM_SEL_HALF: ld_result = {{16{ld_sign & ld_shifted[15]}}, ld_shifted[15:0]};
      default:      ld_result = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage sequencer between the decoded memory-control bundle and the
// single-port data RAM. Checks alignment, launches one req/ack bus cycle per
// access, stalls the pipeline meanwhile and returns the aligned, extended
// load result.
//   Bundle in : mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
//               mem_write_data, mem_addr, flush
//   RAM bus   : ram_req/ram_we/ram_be/ram_addr/ram_wdata out, ram_ack/ram_rdata in
//   Pipeline  : stall_req, load_data, load_valid,
//               addr_err_load/addr_err_store (combinational), bus_err
// Optional macro MEM_TIMEOUT_EN: abandon a bus cycle after TIMEOUT_CYCLES
// cycles without ack and pulse bus_err; otherwise wait for ack forever.
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_flag,
  input  logic                   mem_write_flag,
  input  logic                   mem_sign_ext_flag,
  input  logic [MEM_SEL_BUS-1:0] mem_sel,
  input  logic [DATA_W-1:0]      mem_write_data,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic                   flush,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [RAM_BE_W-1:0]    ram_be,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic                   ram_ack,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic                   stall_req,
  output logic [DATA_W-1:0]      load_data,
  output logic                   load_valid,
  output logic                   addr_err_load,
  output logic                   addr_err_store,
  output logic                   bus_err
);

  logic                  sel_ok, misaligned, access_ok, timeout_hit;
  logic [RAM_BE_W-1:0]   lane_be;
  logic [DATA_W-1:0]     lane_wdata, ld_result;

  mem_state_e            state_q, state_d;
  logic                  ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [RAM_BE_W-1:0]   ram_be_q, ram_be_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d, load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d, bus_err_q, bus_err_d;
  logic [MEM_SEL_BUS-1:0] ld_sel_q, ld_sel_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic                  ld_sign_q, ld_sign_d;

  mem_lane_align u_lane_align (
    .st_sel     (mem_sel),
    .st_off     (mem_addr[1:0]),
    .st_data    (mem_write_data),
    .sel_ok     (sel_ok),
    .misaligned (misaligned),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .ld_sel     (ld_sel_q),
    .ld_off     (ld_off_q),
    .ld_sign    (ld_sign_q),
    .ld_rdata   (ram_rdata),
    .ld_result  (ld_result)
  );

  // A read flag wins over a write flag, so a misaligned bundle with both set
  // is reported as a load fault.
  assign addr_err_load  = mem_read_flag & sel_ok & misaligned;
  assign addr_err_store = ~mem_read_flag & mem_write_flag & sel_ok & misaligned;
  assign access_ok      = (mem_read_flag | mem_write_flag) & sel_ok & ~misaligned;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter restarts whenever the FSM changes state, i.e. on entry to
  // BUSY/ABORT; the hit fires on the last permitted wait cycle.
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  always_comb to_cnt_d = (state_d != state_q) ? '0 : to_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_be_d     = ram_be_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    ld_sel_d     = ld_sel_q;
    ld_off_d     = ld_off_q;
    ld_sign_d    = ld_sign_q;
    stall_req    = 1'b0;

    case (state_q)
      MEM_ST_IDLE: begin
        // bus_err_q blocks a relaunch of the timed-out instruction that is
        // still sitting on the inputs while the pipeline takes the exception.
        if (access_ok && !flush && !bus_err_q) begin
          stall_req   = 1'b1;
          ram_req_d   = 1'b1;
          ram_we_d    = ~mem_read_flag;
          ram_be_d    = lane_be;
          ram_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          ram_wdata_d = lane_wdata;
          ld_sel_d    = mem_sel;
          ld_off_d    = mem_addr[1:0];
          ld_sign_d   = mem_sign_ext_flag;
          state_d     = MEM_ST_BUSY;
        end
      end

      MEM_ST_BUSY: begin
        stall_req = 1'b1;
        if (ram_ack) begin
          ram_req_d = 1'b0;
          if (flush) begin
            state_d = MEM_ST_IDLE;
          end else begin
            state_d = MEM_ST_DONE;
            if (!ram_we_q) begin
              load_data_d  = ld_result;
              load_valid_d = 1'b1;
            end
          end
        end else if (flush) begin
          state_d = MEM_ST_ABORT;
        end else if (timeout_hit) begin
          ram_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = MEM_ST_IDLE;
        end
      end

      MEM_ST_ABORT: begin
        // The bus cycle must still finish; only a newly presented access
        // needs to be held back.
        stall_req = access_ok & ~flush;
        if (ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = MEM_ST_IDLE;
        end else if (timeout_hit) begin
          ram_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = MEM_ST_IDLE;
        end
      end

      // The finished instruction is still on the inputs: never relaunch here.
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MEM_ST_IDLE;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_be_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      ld_sel_q     <= '0;
      ld_off_q     <= '0;
      ld_sign_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_be_q     <= ram_be_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      ld_sel_q     <= ld_sel_d;
      ld_off_q     <= ld_off_d;
      ld_sign_q    <= ld_sign_d;
    end
  end

  assign ram_req    = ram_req_q;
  assign ram_we     = ram_we_q;
  assign ram_be     = ram_be_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign load_data  = load_data_q;
  // A flush arriving in the DONE cycle squashes the result.
  assign load_valid = load_valid_q & ~flush;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. The bench plays the pipeline and
// the bus slave; expected bus fields and load results come from a byte-level
// reference model. With MEM_TIMEOUT_EN defined the timeout path is checked,
// otherwise the indefinite wait is checked.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam logic [3:0] SEL_B = 4'b0001;
  localparam logic [3:0] SEL_H = 4'b0011;
  localparam logic [3:0] SEL_W = 4'b1111;
  localparam int         TO    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag, flush;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data, mem_addr;
  logic        ram_req, ram_we, ram_ack;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, load_data;
  logic        stall_req, load_valid, addr_err_load, addr_err_store, bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int req_cyc  = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .mem_addr          (mem_addr),
    .flush             (flush),
    .ram_req           (ram_req),
    .ram_we            (ram_we),
    .ram_be            (ram_be),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_ack           (ram_ack),
    .ram_rdata         (ram_rdata),
    .stall_req         (stall_req),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .addr_err_load     (addr_err_load),
    .addr_err_store    (addr_err_store),
    .bus_err           (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int size_of(input logic [3:0] sel);
    case (sel)
      SEL_B:   return 1;
      SEL_H:   return 2;
      SEL_W:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] sel, input logic [31:0] addr);
    logic [3:0] be = '0;
    int n = size_of(sel);
    int off = int'(addr[1:0]);
    for (int i = 0; i < n; i++) be[off + i] = 1'b1;
    return be;
  endfunction

  // Every lane j carries store byte (j mod size), so the byte lands
  // correctly whichever lanes are enabled.
  function automatic logic [31:0] exp_wdata(input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    int n = size_of(sel);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = d[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [3:0] sel, input logic sgn);
    longint v = 0;
    int n = size_of(sel);
    int off = int'(addr[1:0]);
    for (int i = 0; i < n; i++) v += longint'(rdata[8*(off + i) +: 8]) << (8*i);
    if (sgn && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_bundle(input logic rd, input logic wr, input logic sgn,
                            input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] d);
    mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sgn;
    mem_sel = sel; mem_addr = addr; mem_write_data = d;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_bundle(1'b0, 1'b0, 1'b0, 4'b0000, $urandom, $urandom);
    flush = 1'b0; ram_ack = 1'b0;
    #1;
    check("idle_req", ram_req, 0);
    check("idle_stall", stall_req, 0);
  endtask

  // One full access as seen from the pipeline: present the bundle in IDLE,
  // ack in the ack_wait-th request cycle, then check the DONE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic sgn,
                            input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] d, input logic [31:0] rdata,
                            input int ack_wait, input logic flush_done);
    int  n      = size_of(sel);
    bit  active = (rd | wr) && (n != 0);
    bit  mis    = active && ((int'(addr[1:0]) % (n == 0 ? 1 : n)) != 0);
    @(negedge clk);
    set_bundle(rd, wr, sgn, sel, addr, d);
    flush = 1'b0; ram_ack = 1'b0; ram_rdata = $urandom;
    #1;
    check("launch_req", ram_req, 0);
    check("launch_lv", load_valid, 0);
    check("err_load", addr_err_load, rd & mis);
    check("err_store", addr_err_store, !rd & wr & mis);
    check("launch_stall", stall_req, active & !mis);
    if (!active || mis) begin
      @(negedge clk);
      set_bundle(1'b0, 1'b0, 1'b0, 4'b0000, $urandom, $urandom);
      #1;
      check("noacc_req", ram_req, 0);
      check("noacc_stall", stall_req, 0);
      return;
    end
    for (int k = 1; k <= ack_wait; k++) begin
      @(negedge clk);
      ram_ack   = (k == ack_wait);
      ram_rdata = (k == ack_wait) ? rdata : $urandom;
      #1;
      if (k == 1) req_cyc = cyc;
      check("busy_req", ram_req, 1);
      check("busy_stall", stall_req, 1);
      check("busy_we", ram_we, !rd);
      check("busy_be", ram_be, exp_be(sel, addr));
      check("busy_addr", ram_addr, addr & 32'hFFFF_FFFC);
      check("busy_wdata", ram_wdata, exp_wdata(sel, d));
      check("busy_bus_err", bus_err, 0);
    end
    @(negedge clk);
    ram_ack = 1'b0; ram_rdata = $urandom; flush = flush_done;
    #1;
    check("done_req", ram_req, 0);
    check("done_stall", stall_req, 0);
    check("done_lv", load_valid, rd & !flush_done);
    if (rd) check("done_data", load_data, exp_load(rdata, addr, sel, sgn));
  endtask

  initial begin
    int t0;
    rst = 1'b1; flush = 1'b0; ram_ack = 1'b0; ram_rdata = '0;
    set_bundle(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", ram_req, 0);
    check("rst_we", ram_we, 0);
    check("rst_be", ram_be, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_ldata", load_data, 0);
    check("rst_lv", load_valid, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall", stall_req, 0);
    rst = 1'b0;

    // Word store, ack in the second request cycle.
    run_access(1'b0, 1'b1, 1'b0, SEL_W, 32'h104, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    check("sw_be", ram_be, 4'b1111);
    check("sw_addr", ram_addr, 32'h104);
    check("sw_wdata", ram_wdata, 32'hDEADBEEF);

    // Signed / unsigned byte loads from the top lane.
    run_access(1'b1, 1'b0, 1'b1, SEL_B, 32'h203, 32'h0, 32'h80112233, 1, 1'b0);
    check("lb_data", load_data, 32'hFFFFFF80);
    run_access(1'b1, 1'b0, 1'b0, SEL_B, 32'h203, 32'h0, 32'h80112233, 1, 1'b0);
    check("lbu_data", load_data, 32'h00000080);

    // Half store to the upper lanes, then a misaligned half load.
    run_access(1'b0, 1'b1, 1'b0, SEL_H, 32'h002, 32'h0000ABCD, 32'h0, 1, 1'b0);
    check("sh_be", ram_be, 4'b1100);
    check("sh_wdata", ram_wdata, 32'hABCDABCD);
    run_access(1'b1, 1'b0, 1'b1, SEL_H, 32'h001, 32'h0, 32'h0, 1, 1'b0);

    // Flush while BUSY: request held until ack, result dropped, queued SW
    // launches the cycle after the ack.
    @(negedge clk); set_bundle(1'b1, 1'b0, 1'b0, SEL_W, 32'h300, 32'h0); flush = 1'b0;
    @(negedge clk); flush = 1'b1; #1;
    check("fl_busy_req", ram_req, 1);
    @(negedge clk); flush = 1'b0; set_bundle(1'b0, 1'b1, 1'b0, SEL_W, 32'h400, 32'h12345678); #1;
    check("abort_req", ram_req, 1);
    check("abort_stall", stall_req, 1);
    check("abort_lv", load_valid, 0);
    @(negedge clk); ram_ack = 1'b1; #1;
    check("abort_req2", ram_req, 1);
    run_access(1'b0, 1'b1, 1'b0, SEL_W, 32'h400, 32'h12345678, 32'h0, 1, 1'b0);

    // Back-to-back LW then SW with immediate acks: requests 3 cycles apart.
    run_access(1'b1, 1'b0, 1'b0, SEL_W, 32'h500, 32'h0, 32'hCAFEF00D, 1, 1'b0);
    t0 = req_cyc;
    run_access(1'b0, 1'b1, 1'b0, SEL_W, 32'h504, 32'h55AA55AA, 32'h0, 1, 1'b0);
    check("b2b_spacing", req_cyc - t0, 3);

    // Ack and flush in the same cycle: complete, no load_valid.
    @(negedge clk); set_bundle(1'b1, 1'b0, 1'b0, SEL_W, 32'h600, 32'h0); flush = 1'b0;
    @(negedge clk); ram_ack = 1'b1; ram_rdata = 32'h11112222; flush = 1'b1; #1;
    check("ackfl_req", ram_req, 1);
    @(negedge clk); ram_ack = 1'b0; flush = 1'b0; set_bundle(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0); #1;
    check("ackfl_req_drop", ram_req, 0);
    check("ackfl_lv", load_valid, 0);
    check("ackfl_stall", stall_req, 0);

    // Flush in IDLE launches nothing.
    @(negedge clk); set_bundle(1'b1, 1'b0, 1'b0, SEL_W, 32'h700, 32'h0); flush = 1'b1; #1;
    check("flidle_stall", stall_req, 0);
    idle_cycle();

    // Flush in DONE suppresses load_valid.
    run_access(1'b1, 1'b0, 1'b1, SEL_H, 32'h702, 32'h0, 32'h8001FFFF, 2, 1'b1);
    idle_cycle();

    // Ack withheld.
    @(negedge clk); set_bundle(1'b1, 1'b0, 1'b0, SEL_W, 32'h800, 32'h0); #1;
    check("to_launch_stall", stall_req, 1);
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk); #1;
      check("to_wait_req", ram_req, 1);
      check("to_wait_stall", stall_req, 1);
      check("to_wait_bus_err", bus_err, 0);
    end
    @(negedge clk); #1;
    check("to_bus_err", bus_err, 1);
    check("to_req", ram_req, 0);
    check("to_stall", stall_req, 0);
    check("to_lv", load_valid, 0);
    idle_cycle();
    check("to_bus_err_pulse", bus_err, 0);
`else
    for (int k = 1; k <= 3 * TO; k++) begin
      @(negedge clk); #1;
      check("wait_req", ram_req, 1);
      check("wait_stall", stall_req, 1);
      check("wait_bus_err", bus_err, 0);
    end
    @(negedge clk); ram_ack = 1'b1;
    @(negedge clk); ram_ack = 1'b0; #1;
    check("wait_done_req", ram_req, 0);
    idle_cycle();
`endif

    // Reset mid-transaction.
    @(negedge clk); set_bundle(1'b1, 1'b0, 1'b0, SEL_W, 32'h900, 32'h0);
    @(negedge clk); #1;
    check("mid_req", ram_req, 1);
    rst = 1'b1; set_bundle(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0);
    @(negedge clk); #1;
    check("mid_rst_req", ram_req, 0);
    check("mid_rst_stall", stall_req, 0);
    check("mid_rst_lv", load_valid, 0);
    rst = 1'b0;

    // Randomized accesses.
    for (int i = 0; i < 150; i++) begin
      logic       rd, wr, sgn, fd;
      logic [3:0] sel;
      logic [31:0] addr;
      int          r;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 9) != 0);
      sgn = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 7);
      sel = (r < 3) ? SEL_B : (r < 5) ? SEL_H : (r < 7) ? SEL_W : 4'b0000;
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (sel == SEL_H) addr[0] = 1'b0;
        if (sel == SEL_W) addr[1:0] = 2'b00;
      end
      fd = ($urandom_range(0, 7) == 0);
      run_access(rd, wr, sgn, sel, addr, $urandom, $urandom, $urandom_range(1, 4), fd);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
